// File: rtl/dsel_lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsel_lfsr_pkg : shared types and the single LFSR mixer step function |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dsel_lfsr_pkg;

  typedef logic [63:0] dsel_state_t;
  typedef logic [6:0]  dsel_sym_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } dsel_fsm_t;

  localparam int unsigned SYM_W   = 7;
  localparam int unsigned STATE_W = 64;

  // Seven Fibonacci shifts (taps 64,63,61,60), with sym[i] folded into the
  // i-th shifted-in bit. Taps sit above bit 58, so the symbol never reaches
  // the feedback and lands bit-reversed in state[6:0].
  function automatic dsel_state_t dsel_step(input dsel_state_t state,
                                            input dsel_sym_t   sym);
    dsel_state_t s;
    logic        fb;
    s = state;
    for (int i = 0; i < SYM_W; i++) begin
      fb = s[63] ^ s[62] ^ s[60] ^ s[59] ^ sym[i];
      s  = {s[62:0], fb};
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsel_lfsr_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsel_lfsr_decoder_if : word input, symbol output and status bundle    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface dsel_lfsr_decoder_if #(
  parameter int ERRW = 8
);
  logic        write;
  logic [63:0] initialData;
  logic        pushin;
  logic [63:0] word_in;
  logic        stopin;
  logic        pushout;
  logic [6:0]  dataout;
  logic        mismatch;
  logic        stopout;
  logic        desync;
  logic [15:0] sym_count;
  logic [ERRW-1:0] err_count;

  modport slave (
    input  write, initialData, pushin, word_in, stopout,
    output stopin, pushout, dataout, mismatch, desync, sym_count, err_count
  );

  modport master (
    output write, initialData, pushin, word_in, stopout,
    input  stopin, pushout, dataout, mismatch, desync, sym_count, err_count
  );
endinterface
`default_nettype wire

// File: rtl/dsel_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsel_out_fifo : register FIFO with synchronous flush, full/empty      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dsel_out_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             flush_i,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] din_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] dout_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= din_i;
        wr_q                <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsel_lfsr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dsel_lfsr_decoder : recovers 7-bit symbols from mixer states, checks  |
// | each state against one legal step. Rev 1.0                           |
// +----------------------------------------------------------------------+
module dsel_lfsr_decoder
  import dsel_lfsr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ERRW  = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dsel_lfsr_decoder_if.slave bus
);

  dsel_state_t     state_q;
  dsel_fsm_t       fsm_q;
  logic [15:0]     sym_count_q;
  logic [15:0]     sym_count_d;
  logic [ERRW-1:0] err_count_q;
  logic [ERRW-1:0] err_count_d;

  dsel_state_t     exp_state;
  dsel_sym_t       sym;
  logic            mis;
  logic            accept;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_dout;

  assign bus.stopin = (fsm_q == IDLE) || fifo_full;
  assign accept     = bus.pushin && !bus.stopin && !bus.write;
  assign pop        = !fifo_empty && !bus.stopout;

  // Legal word = zero-symbol step with the symbol XORed into bits 6:0.
  always_comb begin
    exp_state = dsel_step(state_q, '0);
    sym       = '0;
    for (int i = 0; i < SYM_W; i++) begin
      sym[i] = bus.word_in[6-i] ^ exp_state[6-i];
    end
    mis = (bus.word_in[63:7] != exp_state[63:7]);
  end

  assign sym_count_d = sym_count_q + 16'd1;
  assign err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= '0;
      fsm_q       <= IDLE;
      sym_count_q <= '0;
      err_count_q <= '0;
    end else if (bus.write) begin
      state_q     <= bus.initialData;
      fsm_q       <= RUN;
      sym_count_q <= '0;
      err_count_q <= '0;
    end else if (accept) begin
      // A bad word is still adopted so decoding resynchronises on the next one.
      state_q     <= bus.word_in;
      sym_count_q <= sym_count_d;
      if (mis) begin
        err_count_q <= err_count_d;
        fsm_q       <= ERR;
      end
    end
  end

  dsel_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.write),
    .push_i  (accept),
    .din_i   ({mis, sym}),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.pushout   = !fifo_empty;
  assign bus.dataout   = fifo_empty ? 7'd0 : fifo_dout[6:0];
  assign bus.mismatch  = !fifo_empty && fifo_dout[7];
  assign bus.desync    = (fsm_q == ERR);
  assign bus.sym_count = sym_count_q;
  assign bus.err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dsel_lfsr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dsel_lfsr_decoder : table-driven and scripted checks of decoder    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dsel_lfsr_decoder;
  import dsel_lfsr_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   nvec  = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  dsel_lfsr_decoder_if #(.ERRW(8)) bus ();

  dsel_lfsr_decoder #(
    .DEPTH (2),
    .ERRW  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [6:0] sym;
    int         flip;
    logic       exp_mis;
    logic       exp_desync;
    int         exp_err;
  } vec_t;

  vec_t        vt [9];
  dsel_state_t model;
  dsel_state_t wa, wb, wc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic dsel_state_t mk(input dsel_state_t st, input logic [6:0] s, input int flip);
    dsel_state_t w;
    w = dsel_step(st, s);
    if (flip >= 0) w = w ^ (64'd1 << flip);
    return w;
  endfunction

  initial begin
    vt[0] = '{7'h55, -1, 1'b0, 1'b0, 0};
    vt[1] = '{7'h00, -1, 1'b0, 1'b0, 0};
    vt[2] = '{7'h7F, -1, 1'b0, 1'b0, 0};
    vt[3] = '{7'h01, -1, 1'b0, 1'b0, 0};
    vt[4] = '{7'h40, -1, 1'b0, 1'b0, 0};
    vt[5] = '{7'h11, -1, 1'b0, 1'b0, 0};
    vt[6] = '{7'h22, 40, 1'b1, 1'b1, 1};
    vt[7] = '{7'h33, -1, 1'b0, 1'b1, 1};
    vt[8] = '{7'h6A, -1, 1'b0, 1'b1, 1};

    reset = 1'b1;
    bus.write = 1'b0; bus.initialData = '0;
    bus.pushin = 1'b0; bus.word_in = '0; bus.stopout = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_stopin",  64'(bus.stopin),    64'd1);
    check("rst_pushout", 64'(bus.pushout),   64'd0);
    check("rst_dataout", 64'(bus.dataout),   64'd0);
    check("rst_mis",     64'(bus.mismatch),  64'd0);
    check("rst_symcnt",  64'(bus.sym_count), 64'd0);
    check("rst_errcnt",  64'(bus.err_count), 64'd0);
    check("rst_desync",  64'(bus.desync),    64'd0);

    // IDLE refuses words
    bus.pushin = 1'b1; bus.word_in = 64'hDEAD;
    tick();
    bus.pushin = 1'b0;
    check("idle_pushout", 64'(bus.pushout),   64'd0);
    check("idle_symcnt",  64'(bus.sym_count), 64'd0);

    // Seed, then the table streams back to back with no backpressure
    bus.write = 1'b1; bus.initialData = 64'h0123456789ABCDEF;
    tick();
    bus.write = 1'b0;
    model = 64'h0123456789ABCDEF;
    check("seed_stopin", 64'(bus.stopin), 64'd0);
    for (int i = 0; i < 9; i++) begin
      bus.word_in = mk(model, vt[i].sym, vt[i].flip);
      bus.pushin  = 1'b1;
      tick();
      model = bus.word_in;
      check($sformatf("v%0d_pushout", i), 64'(bus.pushout),   64'd1);
      check($sformatf("v%0d_data", i),    64'(bus.dataout),   64'(vt[i].sym));
      check($sformatf("v%0d_mis", i),     64'(bus.mismatch),  64'(vt[i].exp_mis));
      check($sformatf("v%0d_desync", i),  64'(bus.desync),    64'(vt[i].exp_desync));
      check($sformatf("v%0d_symcnt", i),  64'(bus.sym_count), 64'(i + 1));
      check($sformatf("v%0d_errcnt", i),  64'(bus.err_count), 64'(vt[i].exp_err));
    end
    bus.pushin = 1'b0;
    tick();
    check("drain_pushout", 64'(bus.pushout), 64'd0);

    // write clears desync and counters
    bus.write = 1'b1; bus.initialData = 64'hFEDCBA9876543210;
    tick();
    bus.write = 1'b0;
    model = 64'hFEDCBA9876543210;
    check("wr_desync", 64'(bus.desync),    64'd0);
    check("wr_errcnt", 64'(bus.err_count), 64'd0);
    check("wr_symcnt", 64'(bus.sym_count), 64'd0);

    // Backpressure: two fill the FIFO, third is held until space appears
    wa = mk(model, 7'h0A, -1);
    wb = mk(wa, 7'h0B, -1);
    wc = mk(wb, 7'h0C, -1);
    bus.stopout = 1'b1;
    bus.pushin = 1'b1; bus.word_in = wa;
    tick();
    check("bp1_stopin", 64'(bus.stopin), 64'd0);
    bus.word_in = wb;
    tick();
    check("bp2_stopin", 64'(bus.stopin), 64'd1);
    bus.word_in = wc;
    tick();
    check("bp3_stopin", 64'(bus.stopin),    64'd1);
    check("bp3_symcnt", 64'(bus.sym_count), 64'd2);
    check("bp3_head",   64'(bus.dataout),   64'h0A);
    bus.stopout = 1'b0;
    tick();
    check("bp4_head",   64'(bus.dataout), 64'h0B);
    check("bp4_stopin", 64'(bus.stopin),  64'd0);
    tick();
    bus.pushin = 1'b0;
    check("bp5_head",   64'(bus.dataout),   64'h0C);
    check("bp5_symcnt", 64'(bus.sym_count), 64'd3);
    tick();
    check("bp6_pushout", 64'(bus.pushout), 64'd0);

    // write beats pushin in the same cycle
    bus.write = 1'b1; bus.initialData = 64'h0;
    bus.pushin = 1'b1; bus.word_in = mk(wc, 7'h0D, -1);
    tick();
    bus.write = 1'b0; bus.pushin = 1'b0;
    check("wp_pushout", 64'(bus.pushout),   64'd0);
    check("wp_symcnt",  64'(bus.sym_count), 64'd0);
    bus.pushin = 1'b1; bus.word_in = mk(64'h0, 7'h3C, -1);
    tick();
    bus.pushin = 1'b0;
    check("wp_zero_data", 64'(bus.dataout),  64'h3C);
    check("wp_zero_mis",  64'(bus.mismatch), 64'd0);
    model = mk(64'h0, 7'h3C, -1);
    tick();

    // Reset with a full FIFO and a logged error
    bus.stopout = 1'b1;
    bus.pushin = 1'b1; bus.word_in = mk(model, 7'h21, 63);
    tick();
    model = bus.word_in;
    bus.word_in = mk(model, 7'h12, -1);
    tick();
    bus.pushin = 1'b0;
    check("pre_rst_stopin", 64'(bus.stopin),    64'd1);
    check("pre_rst_desync", 64'(bus.desync),    64'd1);
    check("pre_rst_errcnt", 64'(bus.err_count), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r6_pushout", 64'(bus.pushout),   64'd0);
    check("r6_stopin",  64'(bus.stopin),    64'd1);
    check("r6_symcnt",  64'(bus.sym_count), 64'd0);
    check("r6_errcnt",  64'(bus.err_count), 64'd0);
    check("r6_desync",  64'(bus.desync),    64'd0);
    check("r6_dataout", 64'(bus.dataout),   64'd0);
    bus.stopout = 1'b0;

    // err_count saturates
    bus.write = 1'b1; bus.initialData = 64'h5A5A5A5A5A5A5A5A;
    tick();
    bus.write = 1'b0;
    model = 64'h5A5A5A5A5A5A5A5A;
    for (int i = 0; i < 260; i++) begin
      bus.word_in = mk(model, 7'(i), 50);
      bus.pushin  = 1'b1;
      tick();
      model = bus.word_in;
    end
    bus.pushin = 1'b0;
    check("sat_errcnt", 64'(bus.err_count), 64'd255);
    check("sat_symcnt", 64'(bus.sym_count), 64'd260);
    check("sat_mis",    64'(bus.mismatch),  64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
